// File: rtl/ikaopll_pkg.sv
// Shared OPLL package: LFO defaults, TEST register bit map and the PM step type shared with the PG.
package ikaopll_pkg;

    localparam int unsigned AM_MAX_DEFAULT      = 105;
    localparam int unsigned PM_PRESC_W_DEFAULT  = 10;
    localparam int unsigned AM_PRESC_W_DEFAULT  = 6;

    localparam int unsigned TEST_FAST_LFO       = 3;
    localparam int unsigned TEST_LFO_CLR        = 1;

    localparam int unsigned PM_CNT_W            = 3;
    localparam int unsigned AM_LVL_W            = 7;
    localparam int unsigned AM_VAL_W            = 4;
    localparam int unsigned TEST_W              = 4;

    typedef logic [PM_CNT_W-1:0] pm_step_t;

    typedef enum logic {
        AM_UP   = 1'b0,
        AM_DOWN = 1'b1
    } am_dir_e;

endpackage

// File: rtl/ikaopll_lfo_if.sv
// LFO bus: frame timing and TEST controls in, vibrato/tremolo values out.
interface ikaopll_lfo_if;

    logic                                   i_phi1_NCEN_n;
    logic                                   i_CYCLE_21;
    logic [ikaopll_pkg::TEST_W-1:0]         i_TEST;
    ikaopll_pkg::pm_step_t                  o_PMVAL;
    logic [ikaopll_pkg::AM_VAL_W-1:0]       o_AMVAL;

    modport master (
        output i_phi1_NCEN_n,
        output i_CYCLE_21,
        output i_TEST,
        input  o_PMVAL,
        input  o_AMVAL
    );

    modport slave (
        input  i_phi1_NCEN_n,
        input  i_CYCLE_21,
        input  i_TEST,
        output o_PMVAL,
        output o_AMVAL
    );

endinterface

// File: rtl/ikaopll_lfo_am_tri.sv
// Tremolo level generator: 0..AM_MAX..0 triangle; peak and trough each held for exactly one step.
module ikaopll_lfo_am_tri
    import ikaopll_pkg::*;
#(
    parameter int unsigned AM_MAX = AM_MAX_DEFAULT
) (
    input  logic                emuclk,
    input  logic                i_RST_n,
    input  logic                i_tick,
    input  logic                i_clr,
    input  logic                i_step,
    output logic [AM_LVL_W-1:0] am_level,
    output am_dir_e             am_dir
);

    logic [AM_LVL_W-1:0] am_level_nxt;
    am_dir_e             am_dir_nxt;

    // State register.
    always_ff @(posedge emuclk) begin
        if (!i_RST_n) begin
            am_level <= '0;
            am_dir   <= AM_UP;
        end else begin
            am_level <= am_level_nxt;
            am_dir   <= am_dir_nxt;
        end
    end

    // Next level/direction; direction flips in the same step that lands on a turning point.
    always_comb begin
        am_level_nxt = am_level;
        am_dir_nxt   = am_dir;
        if (i_tick) begin
            if (i_clr) begin
                am_level_nxt = '0;
                am_dir_nxt   = AM_UP;
            end else if (i_step) begin
                if (am_dir == AM_UP) begin
                    am_level_nxt = am_level + AM_LVL_W'(1);
                    if (am_level_nxt == AM_LVL_W'(AM_MAX)) begin
                        am_dir_nxt = AM_DOWN;
                    end
                end else begin
                    am_level_nxt = am_level - AM_LVL_W'(1);
                    if (am_level_nxt == '0) begin
                        am_dir_nxt = AM_UP;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ikaopll_lfo.sv
// OPLL global LFO: per-frame vibrato step (o_PMVAL) and tremolo attenuation (o_AMVAL).
// Optional IKAOPLL_LFO_DEBUG_EN adds the o_DBG_STATE snapshot port.
module ikaopll_lfo
    import ikaopll_pkg::*;
#(
    parameter int unsigned PM_PRESC_W = PM_PRESC_W_DEFAULT,
    parameter int unsigned AM_PRESC_W = AM_PRESC_W_DEFAULT,
    parameter int unsigned AM_MAX     = AM_MAX_DEFAULT
) (
    input  logic            emuclk,
    input  logic            i_RST_n,
    ikaopll_lfo_if.slave    lfo_bus
`ifdef IKAOPLL_LFO_DEBUG_EN
    ,
    output logic [22:0]     o_DBG_STATE
`endif
);

    logic [PM_PRESC_W-1:0] pm_presc;
    logic [AM_PRESC_W-1:0] am_presc;
    pm_step_t              pm_cnt;
    logic [AM_LVL_W-1:0]   am_level;
    am_dir_e               am_dir;

    logic frame_tick;
    logic lfo_fast;
    logic lfo_clr;
    logic am_step;

    // Frame tick qualification and TEST decode.
    always_comb begin
        frame_tick = !lfo_bus.i_phi1_NCEN_n && lfo_bus.i_CYCLE_21;
        lfo_fast   = lfo_bus.i_TEST[TEST_FAST_LFO];
        lfo_clr    = lfo_bus.i_TEST[TEST_LFO_CLR];
        am_step    = lfo_fast || (&am_presc);
    end

    // Prescalers and vibrato counter; a slow step fires on the tick where the prescaler wraps.
    always_ff @(posedge emuclk) begin
        if (!i_RST_n) begin
            pm_presc <= '0;
            am_presc <= '0;
            pm_cnt   <= '0;
        end else if (frame_tick) begin
            if (lfo_clr) begin
                pm_presc <= '0;
                am_presc <= '0;
                pm_cnt   <= '0;
            end else begin
                pm_presc <= pm_presc + PM_PRESC_W'(1);
                am_presc <= am_presc + AM_PRESC_W'(1);
                if (lfo_fast || (&pm_presc)) begin
                    pm_cnt <= pm_cnt + PM_CNT_W'(1);
                end
            end
        end
    end

    ikaopll_lfo_am_tri #(
        .AM_MAX     (AM_MAX)
    ) u_am_tri (
        .emuclk     (emuclk),
        .i_RST_n    (i_RST_n),
        .i_tick     (frame_tick),
        .i_clr      (lfo_clr),
        .i_step     (am_step),
        .am_level   (am_level),
        .am_dir     (am_dir)
    );

    // Outputs come straight from state flops, so they hold for the whole frame.
    assign lfo_bus.o_PMVAL = pm_cnt;
    assign lfo_bus.o_AMVAL = am_level[AM_LVL_W-1:AM_LVL_W-AM_VAL_W];

`ifdef IKAOPLL_LFO_DEBUG_EN
    // Debug snapshot, taken directly from the state registers.
    assign o_DBG_STATE = {1'(am_dir), am_level, pm_cnt, 6'(am_presc), 6'(pm_presc)};
`endif

    // TEST bits owned by other blocks; level LSBs only visible through the debug port.
    logic unused_ok;
    assign unused_ok = &{1'b0, lfo_bus.i_TEST[2], lfo_bus.i_TEST[0], 1'(am_dir), am_level[2:0]};

endmodule
